// File: rtl/tetris_key_das_if.sv
// Keyboard/vsync inputs and one-clock game-action pulses between the SoC glue and the game logic.
interface tetris_key_das_if;
  logic [7:0] keycode;
  logic       vga_vs;
  logic       game_active;
  logic       move_left;
  logic       move_right;
  logic       soft_drop;
  logic       rotate_cw;
  logic       rotate_ccw;
  logic [4:0] das_count;

  modport master (
    output keycode, vga_vs, game_active,
    input  move_left, move_right, soft_drop, rotate_cw, rotate_ccw, das_count
  );

  modport slave (
    input  keycode, vga_vs, game_active,
    output move_left, move_right, soft_drop, rotate_cw, rotate_ccw, das_count
  );
endinterface

// File: rtl/tetris_key_das.sv
// Frame-synchronous key decoder with NES-style DAS, periodic soft drop and edge-only rotation.
// Pulses land the cycle after the synchronised vsync falling edge; no backpressure, one action per frame.
module tetris_key_das #(
  parameter logic [7:0] KEY_LEFT    = 8'h04,
  parameter logic [7:0] KEY_RIGHT   = 8'h07,
  parameter logic [7:0] KEY_DOWN    = 8'h16,
  parameter logic [7:0] KEY_ROT_CCW = 8'h0D,
  parameter logic [7:0] KEY_ROT_CW  = 8'h0E,
  parameter int         DAS_INIT    = 16,
  parameter int         DAS_REPEAT  = 6,
  parameter int         DROP_PERIOD = 2
) (
  input  logic             i_clk_clk,
  input  logic             i_reset_reset_n,
  tetris_key_das_if.slave  io_key
);

  typedef enum logic [2:0] {IDLE, SHIFT_L, SHIFT_R, DROP, ROT_WAIT} state_e;
  typedef enum logic [2:0] {K_NONE, K_LEFT, K_RIGHT, K_DOWN, K_CW, K_CCW} key_e;

  localparam logic [4:0] LP_DAS_LAST   = 5'(DAS_INIT - 1);
  localparam logic [4:0] LP_DAS_RELOAD = 5'(DAS_INIT - DAS_REPEAT);
  localparam logic [7:0] LP_DROP_LAST  = 8'(DROP_PERIOD - 1);

  // Pulse vector bit order: left, right, drop, cw, ccw
  localparam logic [4:0] P_LEFT  = 5'b00001;
  localparam logic [4:0] P_RIGHT = 5'b00010;
  localparam logic [4:0] P_DROP  = 5'b00100;
  localparam logic [4:0] P_CW    = 5'b01000;
  localparam logic [4:0] P_CCW   = 5'b10000;

  logic       r_vs_s1;
  logic       r_vs_s2;
  logic       r_vs_d;
  state_e     r_state;
  key_e       r_key;
  logic [4:0] r_das;
  logic [7:0] r_drop;
  logic [4:0] r_pulse;

  logic       w_frame_tick;
  key_e       w_key;
  state_e     w_state_nxt;
  key_e       w_key_nxt;
  logic [4:0] w_das_nxt;
  logic [7:0] w_drop_nxt;
  logic [4:0] w_pulse_nxt;

  assign w_frame_tick = r_vs_d & ~r_vs_s2;

  // Anything outside the five mapped codes behaves exactly like a release.
  always_comb begin
    w_key = K_NONE;
    if      (io_key.keycode == KEY_LEFT)    w_key = K_LEFT;
    else if (io_key.keycode == KEY_RIGHT)   w_key = K_RIGHT;
    else if (io_key.keycode == KEY_DOWN)    w_key = K_DOWN;
    else if (io_key.keycode == KEY_ROT_CW)  w_key = K_CW;
    else if (io_key.keycode == KEY_ROT_CCW) w_key = K_CCW;
  end

  always_ff @(posedge i_clk_clk or negedge i_reset_reset_n) begin
    if (!i_reset_reset_n) begin
      r_vs_s1 <= 1'b1;
      r_vs_s2 <= 1'b1;
      r_vs_d  <= 1'b1;
      r_state <= IDLE;
      r_key   <= K_NONE;
      r_das   <= '0;
      r_drop  <= '0;
      r_pulse <= '0;
    end else begin
      r_vs_s1 <= io_key.vga_vs;
      r_vs_s2 <= r_vs_s1;
      r_vs_d  <= r_vs_s2;
      r_state <= w_state_nxt;
      r_key   <= w_key_nxt;
      r_das   <= w_das_nxt;
      r_drop  <= w_drop_nxt;
      r_pulse <= w_pulse_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_key_nxt   = r_key;
    w_das_nxt   = r_das;
    w_drop_nxt  = r_drop;
    w_pulse_nxt = '0;
    if (w_frame_tick) begin
      w_key_nxt = w_key;
      if (!io_key.game_active) begin
        // Forgetting the held key makes it a fresh press once play resumes.
        w_state_nxt = IDLE;
        w_key_nxt   = K_NONE;
        w_das_nxt   = '0;
        w_drop_nxt  = '0;
      end else if (r_state == ROT_WAIT && w_key == r_key) begin
        w_state_nxt = ROT_WAIT;
      end else begin
        case (w_key)
          K_LEFT, K_RIGHT: begin
            w_drop_nxt = '0;
            if ((w_key == K_LEFT  && r_state == SHIFT_L) ||
                (w_key == K_RIGHT && r_state == SHIFT_R)) begin
              if (r_das == LP_DAS_LAST) begin
                w_das_nxt   = LP_DAS_RELOAD;
                w_pulse_nxt = (w_key == K_LEFT) ? P_LEFT : P_RIGHT;
              end else begin
                w_das_nxt = r_das + 5'd1;
              end
            end else begin
              w_state_nxt = (w_key == K_LEFT) ? SHIFT_L : SHIFT_R;
              w_das_nxt   = '0;
              w_pulse_nxt = (w_key == K_LEFT) ? P_LEFT : P_RIGHT;
            end
          end
          K_DOWN: begin
            w_das_nxt = '0;
            if (r_state == DROP) begin
              if (r_drop >= LP_DROP_LAST) begin
                w_drop_nxt  = '0;
                w_pulse_nxt = P_DROP;
              end else begin
                w_drop_nxt = r_drop + 8'd1;
              end
            end else begin
              w_state_nxt = DROP;
              w_drop_nxt  = '0;
              w_pulse_nxt = P_DROP;
            end
          end
          K_CW, K_CCW: begin
            w_state_nxt = ROT_WAIT;
            w_das_nxt   = '0;
            w_drop_nxt  = '0;
            w_pulse_nxt = (w_key == K_CW) ? P_CW : P_CCW;
          end
          default: begin
            w_state_nxt = IDLE;
            w_das_nxt   = '0;
            w_drop_nxt  = '0;
          end
        endcase
      end
    end
  end

  assign io_key.move_left  = r_pulse[0];
  assign io_key.move_right = r_pulse[1];
  assign io_key.soft_drop  = r_pulse[2];
  assign io_key.rotate_cw  = r_pulse[3];
  assign io_key.rotate_ccw = r_pulse[4];
  assign io_key.das_count  = r_das;

endmodule
